// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// mem_wb_pipe : MEM->WB pipeline register, valid/ready, optional skid entry,
//               flush, multi-lane writeback with x0 suppression, retire count
// Revision    : 1.0
// ============================================================================
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int SKID   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES-1:0]          in_wreg_i,
  input  logic [LANES*ADDR_W-1:0]   in_wd_i,
  input  logic [LANES*DATA_W-1:0]   in_wdata_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES-1:0]          wb_wreg_o,
  output logic [LANES*ADDR_W-1:0]   wb_wd_o,
  output logic [LANES*DATA_W-1:0]   wb_wdata_o,
  output logic [31:0]               retire_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LANES-1:0]          out_wreg_q, out_wreg_d;
  logic [LANES*ADDR_W-1:0]   out_wd_q, out_wd_d;
  logic [LANES*DATA_W-1:0]   out_wdata_q, out_wdata_d;
  logic [LANES-1:0]          skid_wreg_q, skid_wreg_d;
  logic [LANES*ADDR_W-1:0]   skid_wd_q, skid_wd_d;
  logic [LANES*DATA_W-1:0]   skid_wdata_q, skid_wdata_d;
  logic [31:0]               retire_cnt_q, retire_cnt_d;

  logic                      w_accept;
  logic                      w_retire;
  logic [31:0]               w_pop;

  assign out_valid_o  = (state_q != ST_EMPTY);
  assign w_accept     = in_valid_i & in_ready_o;
  assign w_retire     = out_valid_o & out_ready_i;
  assign retire_cnt_o = retire_cnt_q;

  // The registered ready is simply "the next state is not SKID", which keeps
  // out_ready off any combinational path into in_ready.
  if (SKID != 0) begin : g_ready_reg
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= (state_d != ST_SKID);
    end
    assign in_ready_o = in_ready_q;
  end else begin : g_ready_comb
    assign in_ready_o = (state_q == ST_EMPTY) | out_ready_i;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wb_wreg_o[l] = out_valid_o & out_wreg_q[l] &
                          (out_wd_q[l*ADDR_W +: ADDR_W] != '0);
  end

  assign wb_wd_o    = out_valid_o ? out_wd_q    : '0;
  assign wb_wdata_o = out_valid_o ? out_wdata_q : '0;

  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + 32'(wb_wreg_o[l]);
    end
  end

  always_comb begin
    state_d      = state_q;
    out_wreg_d   = out_wreg_q;
    out_wd_d     = out_wd_q;
    out_wdata_d  = out_wdata_q;
    skid_wreg_d  = skid_wreg_q;
    skid_wd_d    = skid_wd_q;
    skid_wdata_d = skid_wdata_q;
    retire_cnt_d = w_retire ? (retire_cnt_q + w_pop) : retire_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          state_d     = ST_FULL;
          out_wreg_d  = in_wreg_i;
          out_wd_d    = in_wd_i;
          out_wdata_d = in_wdata_i;
        end
      end
      ST_FULL: begin
        if (w_accept && w_retire) begin
          out_wreg_d  = in_wreg_i;
          out_wd_d    = in_wd_i;
          out_wdata_d = in_wdata_i;
        end else if (w_accept) begin
          // Only reachable with the skid entry present.
          state_d      = ST_SKID;
          skid_wreg_d  = in_wreg_i;
          skid_wd_d    = in_wd_i;
          skid_wdata_d = in_wdata_i;
        end else if (w_retire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (w_retire) begin
          state_d     = ST_FULL;
          out_wreg_d  = skid_wreg_q;
          out_wd_d    = skid_wd_q;
          out_wdata_d = skid_wdata_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Datapath entries need no reset; the outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    out_wreg_q   <= out_wreg_d;
    out_wd_q     <= out_wd_d;
    out_wdata_q  <= out_wdata_d;
    skid_wreg_q  <= skid_wreg_d;
    skid_wd_q    <= skid_wd_d;
    skid_wdata_q <= skid_wdata_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// tb_mem_wb_pipe : three configurations driven by shared stimulus, checked
//                  against a FIFO-level model of the stage
// Revision       : 1.0
// ============================================================================
module tb_mem_wb_pipe;

  // dut0: LANES=2 SKID=1, dut1: LANES=2 SKID=0, dut2: LANES=1 SKID=1
  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_wreg;
  logic [9:0]  in_wd;
  logic [63:0] in_wdata;

  logic        rdy_a   [3];
  logic        ov_a    [3];
  logic [1:0]  wreg_a  [3];
  logic [9:0]  wd_a    [3];
  logic [63:0] wdata_a [3];
  logic [31:0] cnt_a   [3];

  logic [0:0]  wreg2;
  logic [4:0]  wd2;
  logic [31:0] wdata2;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2), .SKID(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_a[0]), .in_wreg_i(in_wreg), .in_wd_i(in_wd),
    .in_wdata_i(in_wdata), .out_valid_o(ov_a[0]), .out_ready_i(out_ready),
    .wb_wreg_o(wreg_a[0]), .wb_wd_o(wd_a[0]), .wb_wdata_o(wdata_a[0]),
    .retire_cnt_o(cnt_a[0]));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2), .SKID(0)) u_dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_a[1]), .in_wreg_i(in_wreg), .in_wd_i(in_wd),
    .in_wdata_i(in_wdata), .out_valid_o(ov_a[1]), .out_ready_i(out_ready),
    .wb_wreg_o(wreg_a[1]), .wb_wd_o(wd_a[1]), .wb_wdata_o(wdata_a[1]),
    .retire_cnt_o(cnt_a[1]));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(1), .SKID(1)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_a[2]), .in_wreg_i(in_wreg[0:0]), .in_wd_i(in_wd[4:0]),
    .in_wdata_i(in_wdata[31:0]), .out_valid_o(ov_a[2]), .out_ready_i(out_ready),
    .wb_wreg_o(wreg2), .wb_wd_o(wd2), .wb_wdata_o(wdata2),
    .retire_cnt_o(cnt_a[2]));

  assign wreg_a[2]  = {1'b0, wreg2};
  assign wd_a[2]    = {5'd0, wd2};
  assign wdata_a[2] = {32'd0, wdata2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each stage is a FIFO of up to two beats (one for SKID=0)
  logic [1:0]  m_wreg  [3][2];
  logic [9:0]  m_wd    [3][2];
  logic [63:0] m_wdata [3][2];
  int          m_cnt   [3] = '{0, 0, 0};
  logic [31:0] m_ret   [3] = '{32'd0, 32'd0, 32'd0};

  function automatic logic exp_ready(int d);
    if (d == 1) return (m_cnt[d] == 0) || out_ready;
    return m_cnt[d] < 2;
  endfunction

  function automatic logic [1:0] exp_wreg(int d);
    logic [1:0] q;
    q[0] = m_wreg[d][0][0] && (m_wd[d][0][4:0] != 5'd0);
    q[1] = m_wreg[d][0][1] && (m_wd[d][0][9:5] != 5'd0);
    return (m_cnt[d] > 0) ? q : 2'b00;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          m_cnt[d] = 0;
          m_ret[d] = 32'd0;
        end else begin
          logic rdy, ret, acc;
          rdy = exp_ready(d);
          ret = (m_cnt[d] > 0) && out_ready;
          acc = in_valid && rdy;
          if (ret) begin
            m_ret[d]      = m_ret[d] + 32'($countones(exp_wreg(d)));
            m_wreg[d][0]  = m_wreg[d][1];
            m_wd[d][0]    = m_wd[d][1];
            m_wdata[d][0] = m_wdata[d][1];
            m_cnt[d]      = m_cnt[d] - 1;
          end
          if (flush) begin
            m_cnt[d] = 0;
          end else if (acc) begin
            m_wreg[d][m_cnt[d]]  = (d == 2) ? (in_wreg & 2'b01)   : in_wreg;
            m_wd[d][m_cnt[d]]    = (d == 2) ? (in_wd & 10'h01F)   : in_wd;
            m_wdata[d][m_cnt[d]] = (d == 2) ? {32'd0, in_wdata[31:0]} : in_wdata;
            m_cnt[d]             = m_cnt[d] + 1;
          end
        end
      end
    end
  end

  task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        for (int d = 0; d < 3; d++) begin
          logic ov;
          ov = (m_cnt[d] > 0);
          chk("out_valid",  d, 64'(ov_a[d]),   64'(ov));
          chk("in_ready",   d, 64'(rdy_a[d]),  64'(exp_ready(d)));
          chk("wb_wreg",    d, 64'(wreg_a[d]), 64'(exp_wreg(d)));
          chk("wb_wd",      d, 64'(wd_a[d]),   ov ? 64'(m_wd[d][0]) : 64'd0);
          chk("wb_wdata",   d, wdata_a[d],     ov ? m_wdata[d][0]   : 64'd0);
          chk("retire_cnt", d, 64'(cnt_a[d]),  64'(m_ret[d]));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(logic [1:0] wr, logic [4:0] a1, logic [4:0] a0,
                      logic [31:0] d1, logic [31:0] d0);
    in_valid = 1'b1;
    in_wreg  = wr;
    in_wd    = {a1, a0};
    in_wdata = {d1, d0};
  endtask

  initial begin
    logic [31:0] c0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    beat(2'b11, 5'd2, 5'd1, 32'h1111, 32'h2222);

    // reset held two cycles with in_valid high
    repeat (2) step();
    chk_en = 1'b1;
    rst = 1'b0; in_valid = 1'b0;
    #2;
    chk("rst_out_valid", 0, 64'(ov_a[0]), 64'd0);
    chk("rst_wb_wd",     0, 64'(wd_a[0]), 64'd0);
    chk("rst_retire",    0, 64'(cnt_a[0]), 64'd0);
    chk("rst_in_ready",  0, 64'(rdy_a[0]), 64'd1);

    // streaming
    out_ready = 1'b1;
    step(); beat(2'b01, 5'd0, 5'd3, 32'h0, 32'hA);
    step(); beat(2'b01, 5'd0, 5'd4, 32'h0, 32'hB);
    #2 chk("stream_wd3", 2, 64'(wd_a[2]), 64'd3);
    chk("stream_data3", 2, wdata_a[2], 64'hA);
    step(); beat(2'b01, 5'd0, 5'd5, 32'h0, 32'hC);
    #2 chk("stream_wd4", 2, 64'(wd_a[2]), 64'd4);
    step(); in_valid = 1'b0;
    #2 chk("stream_wd5", 2, 64'(wd_a[2]), 64'd5);
    step();
    #2 chk("stream_cnt", 2, 64'(cnt_a[2]), 64'd3);
    chk("stream_cnt", 0, 64'(cnt_a[0]), 64'd3);

    // backpressure into the skid entry
    out_ready = 1'b0;
    step(); beat(2'b01, 5'd0, 5'd1, 32'h0, 32'h100);
    step(); beat(2'b01, 5'd0, 5'd2, 32'h0, 32'h200);
    step(); in_valid = 1'b0;
    #2 chk("bp_in_ready", 0, 64'(rdy_a[0]), 64'd0);
    chk("bp_hold_wd1", 0, 64'(wd_a[0]), 64'd1);
    step();
    #2 chk("bp_hold_wd1b", 0, 64'(wd_a[0]), 64'd1);
    step(); out_ready = 1'b1;
    step();
    #2 chk("bp_wd2", 0, 64'(wd_a[0]), 64'd2);
    chk("bp_ready_back", 0, 64'(rdy_a[0]), 64'd1);
    step();
    #2 chk("bp_drained", 0, 64'(ov_a[0]), 64'd0);

    // x0 suppression
    c0 = cnt_a[0];
    beat(2'b11, 5'd0, 5'd7, 32'h55, 32'h66);
    step(); in_valid = 1'b0;
    #2 chk("x0_wreg", 0, 64'(wreg_a[0]), 64'd1);
    chk("x0_data0", 0, 64'(wdata_a[0][31:0]), 64'h66);
    step();
    #2 chk("x0_cnt", 0, 64'(cnt_a[0]), 64'(c0 + 32'd1));

    // flush while two beats are held
    out_ready = 1'b0;
    step(); beat(2'b01, 5'd0, 5'd9, 32'h0, 32'h9);
    step(); beat(2'b01, 5'd0, 5'd10, 32'h0, 32'h10);
    step(); beat(2'b01, 5'd0, 5'd11, 32'h0, 32'h11); flush = 1'b1;
    #2 chk("fl_skid", 0, 64'(rdy_a[0]), 64'd0);
    step(); flush = 1'b0; in_valid = 1'b0;
    #2 chk("fl_empty", 0, 64'(ov_a[0]), 64'd0);
    chk("fl_ready", 0, 64'(rdy_a[0]), 64'd1);
    step(); out_ready = 1'b1;

    // SKID=0 replace-on-retire
    step(); out_ready = 1'b0; beat(2'b01, 5'd0, 5'd12, 32'h0, 32'h12);
    step(); in_valid = 1'b0;
    #2 chk("s0_full", 1, 64'(rdy_a[1]), 64'd0);
    step(); out_ready = 1'b1; beat(2'b01, 5'd0, 5'd13, 32'h0, 32'h13);
    #2 chk("s0_comb_ready", 1, 64'(rdy_a[1]), 64'd1);
    step(); beat(2'b01, 5'd0, 5'd14, 32'h0, 32'h14);
    #2 chk("s0_wd13", 1, 64'(wd_a[1]), 64'd13);
    step(); beat(2'b01, 5'd0, 5'd15, 32'h0, 32'h15);
    #2 chk("s0_wd14", 1, 64'(wd_a[1]), 64'd14);
    step(); in_valid = 1'b0;
    #2 chk("s0_wd15", 1, 64'(wd_a[1]), 64'd15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst       = ($urandom_range(299) == 0);
      flush     = ($urandom_range(39) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      in_wreg   = 2'($urandom_range(3));
      in_wd[4:0] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      in_wd[9:5] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      in_wdata  = {$urandom, $urandom};
    end
    step(); rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
